// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: handover states,
// opcode constants and the word-alignment helper.
package imem_arbiter_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    DRAIN     = 3'd1,
    WAIT_LOAD = 3'd2,
    LOAD      = 3'd3,
    RELEASE   = 3'd4
  } arb_state_t;

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  // addi x0, x0, 0: harmless filler that is never a branch or jump
  localparam logic [31:0] NOP_INSTR  = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

  function automatic logic word_aligned(input logic [31:0] byte_addr);
    return (byte_addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Loader write-address qualifier: a byte address is writable when it is
// word aligned and lies inside the 2**ADDR_W word memory.
module imem_addr_check
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [31:0] addr_i,
  output logic        wr_ok_o
);

  assign wr_ok_o = word_aligned(addr_i) &&
                   (addr_i[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction RAM between fetch and the program loader,
// draining the pipeline with NOPs before handover and restarting the core after.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DRAIN_CYCLES = 3,
  parameter bit BOOT_WAIT    = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       fetch_address,
  output logic [31:0]       fetch_data,
  output logic              fetch_stall,
  output logic              core_rst_n,
  input  logic              ld_req,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              ld_done,
  output logic              ld_ready,
  output logic              ld_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam int         CNT_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam arb_state_t RESET_STATE = BOOT_WAIT ? WAIT_LOAD : RUN;

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_stall_q, core_rst_n_q, ld_ready_q, ld_err_q, ld_err_d;
  logic             wr_ok_s;
  logic             unused_s;

  assign unused_s = ^{fetch_address[31:ADDR_W+2], fetch_address[1:0]};

  imem_addr_check #(.ADDR_W(ADDR_W)) u_addr_check (
    .addr_i  (ld_addr),
    .wr_ok_o (wr_ok_s)
  );

  // Handover sequencing and sticky error capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_err_d = ld_err_q;
    case (state_q)
      RUN: begin
        if (ld_req) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT_LOAD: begin
        if (ld_req) begin
          state_d = LOAD;
        end else begin
          state_d = WAIT_LOAD;
        end
      end
      LOAD: begin
        if (ld_valid && !wr_ok_s) begin
          ld_err_d = 1'b1;
        end else begin
          ld_err_d = ld_err_q;
        end
        if (ld_done || !ld_req) begin
          state_d = RELEASE;
        end else begin
          state_d = LOAD;
        end
      end
      RELEASE: state_d = RUN;
      default: state_d = RESET_STATE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RESET_STATE;
      cnt_q         <= {CNT_W{1'b0}};
      fetch_stall_q <= BOOT_WAIT;
      core_rst_n_q  <= !BOOT_WAIT;
      ld_ready_q    <= 1'b0;
      ld_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fetch_stall_q <= (state_d != RUN);
      core_rst_n_q  <= (state_d == RUN) || (state_d == DRAIN);
      ld_ready_q    <= (state_d == LOAD);
      ld_err_q      <= ld_err_d;
    end
  end

  // Memory port steering: fetch owns it in RUN, the loader in LOAD
  always_comb begin
    fetch_data = NOP_INSTR;
    mem_addr   = fetch_address[ADDR_W+1:2];
    mem_wdata  = 32'h0000_0000;
    mem_we     = 1'b0;
    case (state_q)
      RUN: fetch_data = mem_rdata;
      LOAD: begin
        mem_addr  = ld_addr[ADDR_W+1:2];
        mem_wdata = ld_wdata;
        mem_we    = ld_valid && wr_ok_s && reset_n;
      end
      default: fetch_data = NOP_INSTR;
    endcase
  end

  assign fetch_stall = fetch_stall_q;
  assign core_rst_n  = core_rst_n_q;
  assign ld_ready    = ld_ready_q;
  assign ld_err      = ld_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a boot-waiting DUT plus a run-immediately
// DUT sharing one behavioural RAM, checked every cycle against a handover model.
module tb_imem_arbiter;

  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 1024;
  localparam int          DRAIN  = 3;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [31:0]       fetch_address, ld_addr, ld_wdata;
  logic              ld_req, ld_valid, ld_done;
  logic [31:0]       fetch_data, mem_wdata, mem_rdata;
  logic              fetch_stall, core_rst_n, ld_ready, ld_err, mem_we;
  logic [ADDR_W-1:0] mem_addr;

  logic [31:0]       f0_address, f0_data, m0_wdata, m0_rdata;
  logic              f0_stall, c0_rst_n, l0_ready, l0_err, m0_we;
  logic [ADDR_W-1:0] m0_addr;

  logic [31:0] ram  [DEPTH] = '{default: 32'h0};
  logic [31:0] gold [DEPTH] = '{default: 32'h0};

  int   n_vec = 0;
  int   n_err = 0;
  logic run_cmp = 1'b0;

  imem_arbiter #(.ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN), .BOOT_WAIT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_address(fetch_address), .fetch_data(fetch_data),
    .fetch_stall(fetch_stall), .core_rst_n(core_rst_n), .ld_req(ld_req), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done), .ld_ready(ld_ready),
    .ld_err(ld_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  imem_arbiter #(.ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN), .BOOT_WAIT(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .fetch_address(f0_address), .fetch_data(f0_data),
    .fetch_stall(f0_stall), .core_rst_n(c0_rst_n), .ld_req(1'b0), .ld_valid(1'b0),
    .ld_addr(32'h0), .ld_wdata(32'h0), .ld_done(1'b0), .ld_ready(l0_ready),
    .ld_err(l0_err), .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_we(m0_we),
    .mem_rdata(m0_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];
  assign m0_rdata  = ram[m0_addr];

  // Behavioural model: who owns the memory and for how long
  logic m_boot, m_load, m_rel, m_err;
  int   m_drain;

  function automatic logic addr_bad(input logic [31:0] a);
    return ((a % 32'd4) != 32'd0) || (a >= 32'd4 * DEPTH);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_boot <= 1'b1; m_load <= 1'b0; m_rel <= 1'b0; m_err <= 1'b0; m_drain <= 0;
    end else if (m_boot) begin
      if (ld_req) begin m_boot <= 1'b0; m_load <= 1'b1; end
    end else if (m_drain != 0) begin
      m_drain <= m_drain - 1;
      if (m_drain == 1) m_load <= 1'b1;
    end else if (m_load) begin
      if (ld_valid) begin
        if (addr_bad(ld_addr)) m_err <= 1'b1;
        else gold[ld_addr / 32'd4] <= ld_wdata;
      end
      if (ld_done || !ld_req) begin m_load <= 1'b0; m_rel <= 1'b1; end
    end else if (m_rel) begin
      m_rel <= 1'b0;
    end else if (ld_req) begin
      m_drain <= DRAIN;
    end
  end

  wire running = !(m_boot || (m_drain != 0) || m_load || m_rel);
  wire exp_we  = m_load && ld_valid && !addr_bad(ld_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (run_cmp) begin
        chk("m_fetch_stall", fetch_stall, !running);
        chk("m_core_rst_n", core_rst_n, running || (m_drain != 0));
        chk("m_ld_ready", ld_ready, m_load);
        chk("m_ld_err", ld_err, m_err);
        chk("m_mem_we", mem_we, exp_we);
        chk("m_fetch_data", fetch_data, running ? gold[(fetch_address / 32'd4) % DEPTH] : NOP);
        if (running) chk("m_mem_addr_fetch", mem_addr, (fetch_address / 32'd4) % DEPTH);
        if (exp_we) begin
          chk("m_mem_addr_ld", mem_addr, ld_addr / 32'd4);
          chk("m_mem_wdata", mem_wdata, ld_wdata);
        end
        chk("m0_stall", f0_stall, 1'b0);
        chk("m0_core_rst_n", c0_rst_n, 1'b1);
        chk("m0_we", m0_we, 1'b0);
        chk("m0_fetch_data", f0_data, gold[(f0_address / 32'd4) % DEPTH]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b1; ld_req = 1'b0; ld_valid = 1'b0; ld_done = 1'b0;
    ld_addr = 32'h0; ld_wdata = 32'h0; fetch_address = 32'h0; f0_address = 32'h0;
    #1 reset_n = 1'b0;
    run_cmp = 1'b1;

    cyc(); mid();
    chk("rst_stall", fetch_stall, 1'b1);
    chk("rst_core_rst_n", core_rst_n, 1'b0);
    chk("rst_ready", ld_ready, 1'b0);
    chk("rst_err", ld_err, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst0_stall", f0_stall, 1'b0);
    chk("rst0_core_rst_n", c0_rst_n, 1'b1);
    cyc(); reset_n = 1'b1;
    mid(); chk("boot_nop", fetch_data, NOP);
    cyc(); mid(); chk("boot_stall", fetch_stall, 1'b1);

    // Boot load: one word then done
    cyc(); ld_req = 1'b1;
    cyc(); ld_valid = 1'b1; ld_addr = 32'h0; ld_wdata = NOP; ld_done = 1'b1;
    mid(); chk("boot_ready", ld_ready, 1'b1); chk("boot_we", mem_we, 1'b1);
    cyc(); ld_valid = 1'b0; ld_done = 1'b0; ld_req = 1'b0;
    mid(); chk("rel_core", core_rst_n, 1'b0); chk("rel_stall", fetch_stall, 1'b1);
    cyc(); mid();
    chk("run_core", core_rst_n, 1'b1); chk("run_stall", fetch_stall, 1'b0);
    chk("run_fetch0", fetch_data, 32'h0000_0013);

    // Run-time reload with drain, bad addresses and done-with-write
    cyc(); fetch_address = 32'h8; ld_req = 1'b1;
    mid(); chk("t_fetch", fetch_data, 32'h0); chk("t_stall", fetch_stall, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); mid();
      chk("drain_nop", fetch_data, NOP); chk("drain_core", core_rst_n, 1'b1);
    end
    cyc(); ld_valid = 1'b1; ld_addr = 32'h20; ld_wdata = 32'hCAFE_F00D;
    mid(); chk("t4_ready", ld_ready, 1'b1); chk("t4_we", mem_we, 1'b1); chk("t4_addr", mem_addr, 32'd8);
    cyc(); ld_addr = 32'h2; ld_wdata = 32'h1111_1111;
    mid(); chk("misaligned_we", mem_we, 1'b0);
    cyc(); ld_addr = 32'h1000; ld_wdata = 32'h2222_2222;
    mid(); chk("range_we", mem_we, 1'b0); chk("err_set", ld_err, 1'b1);
    cyc(); ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF; ld_done = 1'b1;
    mid(); chk("done_we", mem_we, 1'b1); chk("done_addr", mem_addr, 32'd4);
    cyc(); ld_valid = 1'b0; ld_done = 1'b0; ld_req = 1'b0;
    mid(); chk("rel2_core", core_rst_n, 1'b0);
    cyc(); fetch_address = 32'h10;
    mid(); chk("read_w4", fetch_data, 32'hDEAD_BEEF); chk("err_sticky", ld_err, 1'b1);
    cyc(); fetch_address = 32'h20;
    mid(); chk("read_w8", fetch_data, 32'hCAFE_F00D);
    cyc(); fetch_address = 32'h0;
    mid(); chk("w0_intact", fetch_data, 32'h0000_0013);

    // ld_req dropped during drain still passes through LOAD and RELEASE
    cyc(); ld_req = 1'b1; fetch_address = 32'h20;
    cyc(); ld_req = 1'b0;
    mid(); chk("drop_stall", fetch_stall, 1'b1);
    cyc(); cyc(); cyc();
    mid(); chk("drop_load_ready", ld_ready, 1'b1); chk("drop_load_core", core_rst_n, 1'b0);
    cyc();
    mid(); chk("drop_rel_ready", ld_ready, 1'b0); chk("drop_rel_core", core_rst_n, 1'b0);
    cyc();
    mid(); chk("drop_run_core", core_rst_n, 1'b1); chk("drop_run_fetch", fetch_data, 32'hCAFE_F00D);

    // Reset in the middle of a load after three writes
    cyc(); ld_req = 1'b1;
    cyc(); cyc(); cyc();
    cyc(); ld_valid = 1'b1; ld_addr = 32'h40; ld_wdata = 32'hA1A1_A1A1;
    mid(); chk("ab_we1", mem_we, 1'b1);
    cyc(); ld_addr = 32'h44; ld_wdata = 32'hA2A2_A2A2;
    cyc(); ld_addr = 32'h48; ld_wdata = 32'hA3A3_A3A3;
    cyc(); ld_addr = 32'h4C; ld_wdata = 32'hBAD0_BAD0; reset_n = 1'b0;
    mid();
    chk("abort_we", mem_we, 1'b0); chk("abort_stall", fetch_stall, 1'b1);
    chk("abort_core", core_rst_n, 1'b0); chk("abort_ready", ld_ready, 1'b0);
    chk("abort_err", ld_err, 1'b0);
    cyc(); reset_n = 1'b1; ld_valid = 1'b0; ld_req = 1'b0; f0_address = 32'h44;
    mid(); chk("b0_read_w", f0_data, 32'hA2A2_A2A2); chk("b0_stall", f0_stall, 1'b0);
    cyc(); ld_req = 1'b1;
    cyc(); ld_done = 1'b1;
    mid(); chk("reload_ready", ld_ready, 1'b1); chk("reload_we", mem_we, 1'b0);
    cyc(); ld_done = 1'b0; ld_req = 1'b0;
    cyc(); fetch_address = 32'h48;
    mid(); chk("reload_read", fetch_data, 32'hA3A3_A3A3);
    cyc(); fetch_address = 32'h4C;
    mid(); chk("dropped_word", fetch_data, 32'h0);
    cyc();
    run_cmp = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Owns the single-port instruction memory and shares it between the fetch stage (read, every cycle) and the program loader (word writes from the UART/boot path).
- Sequences handover: on a loader request it stalls fetch, feeds NOPs until the pipeline drains, then grants write access.
- On release it restarts the core through a registered core reset.
- Sits between fetch_stage/loader and the instruction RAM, inside the top-level CPU wrapper.

Parameters:
- ADDR_W, 10, word-address width of instruction memory (DEPTH = 2**ADDR_W words)
- DRAIN_CYCLES, 3, cycles of NOP injection before the loader is granted (covers IF/ID/EX)
- BOOT_WAIT, 1, 1 = wait for a load after reset; 0 = run immediately

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- fetch_address  in  32  byte PC from fetch stage
- fetch_data  out  32  instruction to fetch stage
- fetch_stall  out  1  1 = drive fetch pc_write low
- core_rst_n  out  1  registered active-low reset to the rest of the core
- ld_req  in  1  loader requests memory ownership (level)
- ld_valid  in  1  loader write word valid
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  loader write data
- ld_done  in  1  last word / end of load (pulse)
- ld_ready  out  1  arbiter accepts a write this cycle
- ld_err  out  1  sticky error: misaligned or out-of-range write seen
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  32  memory read data (combinational read)

Behaviour:
- Reset values: state = WAIT_LOAD if BOOT_WAIT else RUN; fetch_stall = BOOT_WAIT; core_rst_n = !BOOT_WAIT; ld_ready = 0; ld_err = 0; mem_we = 0; drain counter = 0.
- Reset does not clear memory contents.
- States:
  - RUN: mem_addr = fetch_address[ADDR_W+1:2]; fetch_data = mem_rdata; fetch_stall = 0. ld_req=1 -> DRAIN, counter loaded with DRAIN_CYCLES-1.
  - DRAIN: fetch_stall = 1; fetch_data = NOP (32'h00000013) so no B/J opcode reaches fetch. Counter decrements each cycle; at 0 -> LOAD.
  - WAIT_LOAD: same outputs as DRAIN. ld_req=1 -> LOAD directly.
  - LOAD: core_rst_n = 0; ld_ready = 1. ld_valid=1 -> mem_we = 1, mem_addr = ld_addr[ADDR_W+1:2], mem_wdata = ld_wdata, all in the same cycle.
    - ld_done=1 -> RELEASE; a write with ld_valid in the same cycle still completes.
    - ld_req falling without ld_done -> RELEASE.
  - RELEASE: one cycle; core_rst_n held 0, fetch_stall = 1, then -> RUN. core_rst_n rises on the clock edge entering RUN.
- Write rules:
  - Suppress the write (mem_we = 0) and set ld_err if ld_addr[1:0] != 0 or ld_addr[31:ADDR_W+2] != 0.
  - ld_err clears only on reset_n.
- ld_valid outside LOAD is ignored; ld_ready = 0 there.
- Outputs core_rst_n, fetch_stall, ld_ready and state are registered. fetch_data and mem_* are combinational from the state and inputs.
- ld_req asserted in RUN in the same cycle as a fetch: that fetch completes normally; stall starts next cycle.
- ld_req deasserted during DRAIN: complete the drain, enter LOAD, then exit immediately to RELEASE. The core is always restarted once a drain has begun.
- reset_n low mid-LOAD: abort immediately; any write in flight is dropped (mem_we is 0 while in reset).

Decomposition:
- Shared package (common): arb_state_t enum {RUN, DRAIN, WAIT_LOAD, LOAD, RELEASE} and localparam NOP_INSTR = 32'h00000013 next to the existing opcode constants.
- Optional sub-module imem_addr_check (alignment/range check producing wr_ok) so it can be reused by the data-memory loader. Everything else stays in one module.

Test Plan:
- BOOT_WAIT=1, release reset -> fetch_stall=1, core_rst_n=0 until loader writes 0x00000013 to addr 0x0 and pulses ld_done. Then one RELEASE cycle, core_rst_n=1, fetch_data=mem_rdata for fetch_address=0.
- RUN, ld_req rises at cycle t -> fetch_data=NOP for cycles t+1..t+3, ld_ready=1 at t+4, mem_we follows ld_valid.
- LOAD, ld_addr=0x0000_0002 -> mem_we=0, ld_err=1 and stays 1 after RELEASE; ld_addr=0x0000_1000 (ADDR_W=10) -> same.
- LOAD, ld_valid=1, ld_done=1, ld_addr=0x10, ld_wdata=0xDEADBEEF same cycle -> word 4 written, next state RELEASE.
- Pulse reset_n low mid-LOAD after 3 writes -> all outputs at reset values, previously written words still readable after a reload with BOOT_WAIT=0.
- ld_req dropped during DRAIN -> LOAD entered for one cycle with no write, RELEASE, RUN; core_rst_n pulses low.
